// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// The configuration struct is sized for the largest supported pattern so a
// single type serves every instance; each instance uses only the low bits it
// needs.
package seq_det_pkg;

   // Largest pattern length any instance may be built with (PAT_W <= PAT_W_MAX).
   localparam int PAT_W_MAX = 32;

   // Width of a length field able to hold 0..pat_w.
   function automatic int len_w(input int pat_w);
      return $clog2(pat_w) + 1;
   endfunction

   localparam int LEN_W_MAX = len_w(PAT_W_MAX);

   // Active detector configuration.
   typedef struct packed {
      logic [PAT_W_MAX-1:0] pattern;   // bit 0 = most recent bit in time
      logic [LEN_W_MAX-1:0] len;       // active length, 1..PAT_W
      logic                 overlap;   // 1 = matched bits may be reused
   } seq_cfg_t;

   // Lengths outside 1..pat_w are pulled to the nearest legal value, so a
   // zero length means "single bit" and an oversize one means "full width".
   function automatic int clamp_len(input int len, input int pat_w);
      if (len < 1)
         return 1;
      else if (len > pat_w)
         return pat_w;
      else
         return len;
   endfunction

   // Builds a configuration constant (used for the reset configuration).
   function automatic seq_cfg_t make_cfg(input logic [PAT_W_MAX-1:0] pattern,
                                         input int                   len,
                                         input int                   pat_w,
                                         input logic                 overlap);
      seq_cfg_t cfg;
      cfg.pattern = pattern;
      cfg.len     = LEN_W_MAX'(clamp_len(len, pat_w));
      cfg.overlap = overlap;
      return cfg;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// The count stops at all-ones; sat rises on the increment that reaches
// all-ones and stays high until clr or reset.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   // Count events, holding at all-ones; clear has priority over increment.
   always_ff @(posedge clk or negedge n_rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (!n_rst) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (inc && (count != MAX)) begin
         count <= count + 1'b1;
         if (count == (MAX - 1'b1))
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector.
// Keeps a shift history of valid input bits and a fill level (how many of
// those bits may still take part in a match). The match output is Mealy:
// it compares the history plus the bit being presented right now, so a
// match is flagged in the same cycle as the final pattern bit.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W       = 8,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(8'b0000_1101),
   parameter int               RST_LEN     = 4,
   parameter logic             RST_OVERLAP = 1'b1
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      clear,
   input  logic                      cfg_load,
   input  logic [PAT_W-1:0]          cfg_pattern,
   input  logic [len_w(PAT_W)-1:0]   cfg_len,
   input  logic                      cfg_overlap,
   input  logic                      in_valid,
   input  logic                      in_bit,
   output logic                      match,
   output logic [CNT_W-1:0]          match_count,
   output logic                      count_sat
);

   localparam int       LEN_W   = len_w(PAT_W);
   localparam seq_cfg_t RST_CFG = make_cfg(PAT_W_MAX'(RST_PATTERN), RST_LEN,
                                           PAT_W, RST_OVERLAP);

   // Active configuration.
   logic [PAT_W-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic             overlap;

   // The oldest history bit would only ever be shifted out, never compared:
   // the candidate word already spans PAT_W bits including in_bit, so the
   // history keeps PAT_W-1 bits.
   logic [PAT_W-2:0] hist;
   logic [LEN_W-1:0] fill;

   logic [PAT_W-1:0] cand;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] len_load;
   logic [LEN_W-1:0] fill_inc;
   logic             hit;
   logic             fill_ok;
   logic             shift;

   assign cand = {hist, in_bit};

   // Build the compare mask (low len bits) and the clamped length to load.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      mask     = '0;
      len_load = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      for (int i = 0; i < PAT_W; i++)
         mask[i] = (i < int'(len));
   end

   // Pattern bits above len are masked out of the compare.
   assign hit     = ((cand ^ pattern) & mask) == '0;
   // The presented bit completes the pattern once len-1 usable bits are held.
   assign fill_ok = fill >= (len - 1'b1);
   // Fill saturates at len: older bits never matter for the compare.
   assign fill_inc = (fill < len) ? fill + 1'b1 : len;

   // Gated by n_rst so the pulse is low throughout reset even for a
   // single-bit reset pattern, where the reset fill would already qualify.
   assign match = n_rst & in_valid & ~clear & ~cfg_load & fill_ok & hit;

   // A valid bit that is not discarded by clear/cfg_load enters the history.
   assign shift = in_valid & ~clear & ~cfg_load;

   // Configuration register: loaded only by cfg_load, kept across clear.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pattern <= RST_CFG.pattern[PAT_W-1:0];
         len     <= RST_CFG.len[LEN_W-1:0];
         overlap <= RST_CFG.overlap;
      end else if (cfg_load) begin
         pattern <= cfg_pattern;
         len     <= len_load;
         overlap <= cfg_overlap;
      end
   end

   // History and fill: flushed by clear or cfg_load, advanced on valid bits.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clear || cfg_load) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= cand[PAT_W-2:0];
         // In non-overlap mode a match consumes its bits: the next match
         // must be built entirely from bits that arrive afterwards.
         if (match && !overlap)
            fill <= '0;
         else
            fill <= fill_inc;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_count (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clear),
      .inc   (match),
      .count (match_count),
      .sat   (count_sat)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param. A bit-queue model of the
// detector is checked against two instances (8-bit and 2-bit counters)
// every cycle; directed sequences also carry literal expectations.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       clear;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       in_valid;
   logic       in_bit;

   logic       match_a;
   logic [7:0] count_a;
   logic       sat_a;
   logic       match_b;
   logic [1:0] count_b;
   logic       sat_b;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: usable valid bits (newest at the back) and configuration.
   bit         mq[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt;

   always #5 clk = ~clk;

   seq_detector_param u_dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (clear),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .match       (match_a),
      .match_count (count_a),
      .count_sat   (sat_a)
   );

   seq_detector_param #(
      .CNT_W (2)
   ) u_dut_small (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (clear),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .match       (match_b),
      .match_count (count_b),
      .count_sat   (sat_b)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int clamp(input int l);
      if (l < 1) return 1;
      if (l > 8) return 8;
      return l;
   endfunction

   // The presented bit plus the newest len-1 usable bits must spell the pattern.
   function automatic bit model_match();
      bit b;
      if (!in_valid || clear || cfg_load) return 1'b0;
      if (mq.size() < m_len - 1) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         b = (k == 0) ? in_bit : mq[mq.size() - k];
         if (b != m_pat[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Compare on the falling edge, then advance the model by the coming rising edge.
   always @(negedge clk) begin
      bit exp;
      if (!n_rst) begin
         mq.delete();
         m_pat = 8'b0000_1101;
         m_len = 4;
         m_ovl = 1'b1;
         m_cnt = 0;
         check("rst_match",   match_a, 0);
         check("rst_match_s", match_b, 0);
         check("rst_count",   count_a, 0);
         check("rst_count_s", count_b, 0);
         check("rst_sat_s",   sat_b,   0);
      end else begin
         exp = model_match();
         check("model_match",   match_a, exp);
         check("model_match_s", match_b, exp);
         check("model_count",   count_a, imin(m_cnt, 255));
         check("model_sat",     sat_a,   m_cnt >= 255);
         check("model_count_s", count_b, imin(m_cnt, 3));
         check("model_sat_s",   sat_b,   m_cnt >= 3);
         if (clear || cfg_load) begin
            mq.delete();
            if (cfg_load) begin
               m_pat = cfg_pattern;
               m_len = clamp(int'(cfg_len));
               m_ovl = cfg_overlap;
            end
            if (clear) m_cnt = 0;
         end else if (in_valid) begin
            if (exp) m_cnt++;
            mq.push_back(in_bit);
            if (exp && !m_ovl) mq.delete();
            while (mq.size() > m_len) void'(mq.pop_front());
         end
      end
   end

   task automatic send(input logic b, input logic exp);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_bit   = b;
      clear    = 1'b0;
      cfg_load = 1'b0;
      #1;
      check("dir_match", match_a, exp);
   endtask

   task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
      logic [15:0] bv;
      logic [15:0] ev;
      bv = bits;
      ev = exps;
      for (int i = n - 1; i >= 0; i--)
         send(bv[i], ev[i]);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      cfg_load = 1'b0;
      #1;
   endtask

   task automatic counts(input int ca, input int cb, input logic sb);
      check("dir_count",   count_a, ca);
      check("dir_count_s", count_b, cb);
      check("dir_sat_s",   sat_b,   sb);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic clr);
      @(posedge clk);
      #1;
      cfg_load    = 1'b1;
      clear       = clr;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_valid    = 1'b1;
      in_bit      = pat[0];
      #1;
      check("load_match", match_a, 0);
   endtask

   task automatic pulse_clear();
      @(posedge clk);
      #1;
      clear    = 1'b1;
      cfg_load = 1'b0;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      #1;
      check("clear_match", match_a, 0);
   endtask

   initial begin
      logic [7:0] s_pat;
      int         s_len;
      int         idx;

      n_rst = 1'b0; clear = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
      cfg_len = '0; cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      #1;
      counts(0, 0, 0);

      // Default 1101 overlapping: matches on bits 4 and 7.
      send_seq(16'b1101101, 16'b0001001, 7);
      settle();
      counts(2, 2, 0);

      // Non-overlapping: fill restarts after the match on bit 4.
      load(8'b0000_1101, 4'd4, 1'b0, 1'b1);
      send_seq(16'b1101101, 16'b0001000, 7);
      settle();
      counts(1, 1, 0);
      send(1'b1, 1'b0);
      send_seq(16'b1101, 16'b0001, 4);
      settle();
      counts(2, 2, 0);

      // Idle cycles hold history and never match.
      load(8'b0000_1101, 4'd4, 1'b1, 1'b1);
      send_seq(16'b110, 16'b000, 3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_bit   = ~in_bit;
         #1;
         check("idle_match", match_a, 0);
      end
      send(1'b1, 1'b1);
      settle();
      check("after_idle_match", match_a, 0);
      counts(1, 1, 0);

      // Reload mid-stream to 010; then length 0 (clamped to 1) with upper pattern bits set.
      send_seq(16'b110, 16'b000, 3);
      load(8'b0000_0010, 4'd3, 1'b1, 1'b0);
      send_seq(16'b01010, 16'b00101, 5);
      settle();
      counts(3, 3, 1);
      load(8'b1010_1011, 4'd0, 1'b0, 1'b0);
      send_seq(16'b101, 16'b101, 3);
      settle();
      counts(5, 3, 1);
      // Oversize length clamps to full 8-bit width.
      load(8'b1010_0110, 4'd15, 1'b1, 1'b0);
      send_seq(16'b10100110, 16'b00000001, 8);
      settle();
      counts(6, 3, 1);

      // Saturation of the 2-bit counter, then clear empties history and counts.
      load(8'b0000_1101, 4'd4, 1'b1, 1'b1);
      settle();
      counts(0, 0, 0);
      for (int m = 0; m < 4; m++) begin
         send_seq(16'b1101, 16'b0001, 4);
         settle();
         counts(m + 1, imin(m + 1, 3), m >= 2);
      end
      send_seq(16'b110, 16'b000, 3);
      pulse_clear();
      settle();
      counts(0, 0, 0);
      send(1'b1, 1'b0);

      // Asynchronous reset mid-cycle discards everything immediately.
      send_seq(16'b1101, 16'b0001, 4);
      send_seq(16'b110, 16'b000, 3);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      #1;
      check("pre_rst_match", match_a, 1);
      #1 n_rst = 1'b0;
      #1;
      check("async_rst_match", match_a, 0);
      counts(0, 0, 0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      in_valid = 1'b0;
      send(1'b1, 1'b0);
      send_seq(16'b1101, 16'b0001, 4);
      settle();
      counts(1, 1, 0);

      // Randomised traffic, half the valid bits steered along the loaded pattern.
      s_pat = 8'b0000_1101;
      s_len = 4;
      idx   = s_len - 1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         clear    = ($urandom_range(0, 299) == 0);
         cfg_load = ($urandom_range(0, 119) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         if (cfg_load) begin
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            s_pat       = cfg_pattern;
            s_len       = clamp(int'(cfg_len));
            idx         = s_len - 1;
         end
         if ($urandom_range(0, 1) == 0) begin
            in_bit = 1'($urandom);
         end else begin
            in_bit = s_pat[idx];
            if (in_valid) idx = (idx == 0) ? s_len - 1 : idx - 1;
         end
      end
      settle();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
